fb_stream_writer: RTL and testbench

//   Write side of the panel framebuffer. Receives a byte stream from the host interface FIFO:
//   one sync byte, then NUM_PIXELS pixels of 3 bytes each (R, G, B). Each pixel is quantised

---
 rtl/fb_stream_writer.sv | 240 ++++++++++++++++++++++++
 tb/tb_fb_stream_writer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_stream_writer.sv
// fb_stream_writer
//   Write side of the panel framebuffer. Parses a host byte stream made of one
//   sync byte followed by NUM_PIXELS RGB triplets, quantises each pixel from
//   24bpp to the 7-7-6 (20-bit) framebuffer format and writes it to the back
//   buffer at linear pixel addresses 0..NUM_PIXELS-1.
//
//   Handshake: a byte transfers on a rising edge where in_valid & in_ready are
//   both high. in_valid may be asserted at any time and in_data must be stable
//   while in_valid is high; in_ready is a combinational function of registered
//   state only (never of in_valid), so there is no combinational loop through
//   the host side.
//
//   Frame hand-off: when the last pixel is written, frame_done pulses and
//   frame_pending is set on the following edge. While pending, the parser sits
//   in HUNT with in_ready low, so the next frame (including its sync byte) is
//   held back until swap_ack releases the back buffer.
//
//   Timeout: inside a frame, a gap of TIMEOUT_CYCLES cycles without an accepted
//   byte aborts the frame, pulses err_timeout and returns to HUNT. Pixels that
//   were already written stay in memory and are overwritten by the next frame.

module fb_stream_writer #(
  parameter int         NUM_PIXELS     = 16384,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [19:0] fb_wdata,
  output logic [13:0] fb_waddr,
  output logic        fb_we,
  input  logic        swap_ack,
  output logic        frame_pending,
  output logic        frame_done,
  output logic        err_timeout,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_HUNT  = 2'd0;
  localparam logic [1:0] S_GET_R = 2'd1;
  localparam logic [1:0] S_GET_G = 2'd2;
  localparam logic [1:0] S_GET_B = 2'd3;

  // Index of the final pixel of a frame.
  localparam logic [13:0] LAST_PIX = 14'(NUM_PIXELS - 1);

  // Idle counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int          TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [13:0]   r_pix_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [6:0]    r_red;
  logic [6:0]    r_grn;
  logic          r_we;
  logic [13:0]   r_waddr;
  logic [19:0]   r_wdata;
  logic          r_done;
  logic          r_pending;
  logic          r_err;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic [1:0] w_state_nxt;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_in_hunt;
  logic       w_sync_accept;
  logic       w_px_accept;
  logic       w_last_px;
  logic       w_timeout;

  // Flow control: HUNT refuses bytes while a finished frame waits for a swap;
  // inside a frame every byte is taken immediately.
  assign w_in_hunt  = (r_state == S_HUNT);
  assign w_in_ready = w_in_hunt ? ~r_pending : 1'b1;
  assign w_accept   = in_valid & w_in_ready;

  // A frame starts only on the sync byte seen while hunting.
  assign w_sync_accept = w_in_hunt & w_accept & (in_data == SYNC_BYTE);

  // The blue byte completes a pixel.
  assign w_px_accept = (r_state == S_GET_B) & w_accept;
  assign w_last_px   = (r_pix_cnt == LAST_PIX);

  // Abort when the idle counter has reached its limit and still nothing came.
  assign w_timeout = ~w_in_hunt & ~w_accept & (r_to_cnt == TO_LAST);

  // Next-state logic for the stream parser; timeout overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HUNT: begin
        if (w_sync_accept) begin
          w_state_nxt = S_GET_R;
        end
      end
      S_GET_R: begin
        if (w_accept) begin
          w_state_nxt = S_GET_G;
        end
      end
      S_GET_G: begin
        if (w_accept) begin
          w_state_nxt = S_GET_B;
        end
      end
      S_GET_B: begin
        if (w_accept) begin
          w_state_nxt = w_last_px ? S_HUNT : S_GET_R;
        end
      end
      default: begin
        w_state_nxt = S_HUNT;
      end
    endcase
    if (w_timeout) begin
      w_state_nxt = S_HUNT;
    end
  end

  // Parser state register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Idle counter: runs inside a frame, cleared by any accepted byte, parked at
  // zero in HUNT and after an abort.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_in_hunt || w_accept || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // Capture the truncated red and green components until blue arrives.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_red <= '0;
      r_grn <= '0;
    end else if (w_accept) begin
      if (r_state == S_GET_R) begin
        r_red <= in_data[7:1];
      end
      if (r_state == S_GET_G) begin
        r_grn <= in_data[7:1];
      end
    end
  end

  // Write pipeline: one cycle after the blue byte, present address and the
  // quantised pixel together with a single-cycle strobe. Address/data hold
  // their last value between strobes.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_px_accept;
      if (w_px_accept) begin
        r_waddr <= r_pix_cnt;
        r_wdata <= {r_red, r_grn, in_data[7:2]};
      end
    end
  end

  // Pixel index: advances after each write and returns to zero after the last
  // pixel, on a new sync or on an abort, so it never leaves 0..NUM_PIXELS-1.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_pix_cnt <= '0;
    end else if (w_timeout || w_sync_accept) begin
      r_pix_cnt <= '0;
    end else if (r_we) begin
      r_pix_cnt <= r_done ? 14'd0 : (r_pix_cnt + 14'd1);
    end
  end

  // frame_done is aligned with the strobe of the final pixel.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_px_accept & w_last_px;
    end
  end

  // Pending flag: set by frame completion, cleared by swap_ack; a completion
  // in the same cycle as an ack keeps it set.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~swap_ack) | r_done;
    end
  end

  // Single-cycle abort indication.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready      = w_in_ready;
  assign fb_we         = r_we;
  assign fb_waddr      = r_waddr;
  assign fb_wdata      = r_wdata;
  assign frame_done    = r_done;
  assign frame_pending = r_pending;
  assign err_timeout   = r_err;
  assign busy          = ~w_in_hunt;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_fb_stream_writer.sv
// Testbench for fb_stream_writer with a small frame (4 pixels) and a short
// idle timeout (16 cycles). Expected framebuffer writes are derived from the
// byte stream by a reference model and checked by a scoreboard.

module tb_fb_stream_writer;

  localparam int NPX = 4;
  localparam int TO  = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        sys_clk  = 1'b0;
  logic        rst      = 1'b1;
  logic [7:0]  in_data  = 8'h00;
  logic        in_valid = 1'b0;
  logic        swap_ack = 1'b0;
  logic        in_ready;
  logic [19:0] fb_wdata;
  logic [13:0] fb_waddr;
  logic        fb_we;
  logic        frame_pending;
  logic        frame_done;
  logic        err_timeout;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 sys_clk = ~sys_clk;

  fb_stream_writer #(
    .NUM_PIXELS     (NPX),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fb_wdata      (fb_wdata),
    .fb_waddr      (fb_waddr),
    .fb_we         (fb_we),
    .swap_ack      (swap_ack),
    .frame_pending (frame_pending),
    .frame_done    (frame_done),
    .err_timeout   (err_timeout),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {frame_done, addr[13:0], data[19:0]}
  logic [34:0] exp_q[$];
  logic [34:0] mon_got;
  logic [34:0] mon_want;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // 7-7-6 truncation expressed arithmetically.
  function automatic logic [19:0] quant(input int r, input int g, input int b);
    return 20'((r / 2) * 8192 + (g / 2) * 64 + (b / 4));
  endfunction

  // Queue the writes produced by the first npix pixels of a frame.
  task automatic expect_pixels(input logic [7:0] px [12], input int npix, input bit full);
    for (int i = 0; i < npix; i++) begin
      exp_q.push_back({(full && i == NPX - 1), 14'(i),
                       quant(px[3*i], px[3*i+1], px[3*i+2])});
    end
  endtask

  task automatic rand_pixels(output logic [7:0] px [12]);
    for (int i = 0; i < 12; i++) px[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(negedge sys_clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_stall in_ready=%b required=1 after %0d cycles", in_ready, n);
    end
    @(negedge sys_clk);
  endtask

  task automatic send_gap(input logic [7:0] b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) @(negedge sys_clk);
    end
    send_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] px [12], input int maxgap);
    send_byte(8'hA5);
    for (int i = 0; i < 12; i++) send_gap(px[i], maxgap);
  endtask

  task automatic do_swap();
    swap_ack = 1'b1;
    @(negedge sys_clk);
    swap_ack = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: every write strobe must match the next expected write
  // ---------------------------------------------------------------------------
  always @(negedge sys_clk) begin
    if (fb_we === 1'b1) begin
      checks++;
      mon_got = {frame_done, fb_waddr, fb_wdata};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got done=%b addr=%0d data=%h required no write",
                 frame_done, fb_waddr, fb_wdata);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL wr_match got done=%b addr=%0d data=%h required done=%b addr=%0d data=%h",
                   mon_got[34], mon_got[33:20], mon_got[19:0],
                   mon_want[34], mon_want[33:20], mon_want[19:0]);
        end
      end
    end else if (frame_done !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL done_without_we frame_done=%b required 0", frame_done);
    end
  end

  task automatic check_drained(input string tag);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending_writes=%0d required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({fb_we, fb_waddr, fb_wdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_wr got we=%b addr=%0d data=%h required 0", fb_we, fb_waddr, fb_wdata);
    end
    checks++;
    if ({frame_pending, frame_done, err_timeout, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got pend=%b done=%b err=%b busy=%b required 0000",
               frame_pending, frame_done, err_timeout, busy);
    end
    rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] px [12];
    time t0;
    for (int i = 0; i < 12; i++) px[i] = 8'((i + 1) * 16);
    exp_q.push_back({1'b0, 14'd0, 7'h08, 7'h10, 6'h0C});
    for (int i = 1; i < NPX; i++)
      exp_q.push_back({(i == NPX - 1), 14'(i), quant(px[3*i], px[3*i+1], px[3*i+2])});
    t0 = $time;
    send_frame(px, 0);
    in_valid = 1'b0;
    checks++;
    if (($time - t0) != 130) begin
      errors++;
      $display("FAIL b2b_rate got %0t required 130 for 13 bytes", $time - t0);
    end
    checks++;
    if ({fb_we, frame_done, fb_waddr} !== {1'b1, 1'b1, 14'd3}) begin
      errors++;
      $display("FAIL b2b_done got we=%b done=%b addr=%0d required 1 1 3", fb_we, frame_done, fb_waddr);
    end
    @(negedge sys_clk);
    checks++;
    if ({frame_pending, in_ready, frame_done} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_pending got pend=%b ready=%b done=%b required 1 0 0",
               frame_pending, in_ready, frame_done);
    end
    check_drained("b2b");
  endtask

  task automatic test_pending_stall();
    logic [7:0] px [12];
    rand_pixels(px);
    expect_pixels(px, NPX, 1'b1);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      checks++;
      if ({in_ready, busy, frame_pending} !== 3'b001) begin
        errors++;
        $display("FAIL stall_hold got ready=%b busy=%b pend=%b required 0 0 1",
                 in_ready, busy, frame_pending);
      end
    end
    do_swap();
    checks++;
    if ({in_ready, frame_pending} !== 2'b10) begin
      errors++;
      $display("FAIL stall_release got ready=%b pend=%b required 1 0", in_ready, frame_pending);
    end
    @(negedge sys_clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_sync busy=%b required 1", busy);
    end
    for (int i = 0; i < 12; i++) send_byte(px[i]);
    in_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (frame_pending !== 1'b1) begin
      errors++;
      $display("FAIL stall_pend2 pend=%b required 1", frame_pending);
    end
    check_drained("stall");
    do_swap();
  endtask

  task automatic test_junk();
    logic [7:0] px [12];
    rand_pixels(px);
    expect_pixels(px, NPX, 1'b1);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL junk_hunt busy=%b required 0", busy);
    end
    send_frame(px, 2);
    in_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (frame_pending !== 1'b1) begin
      errors++;
      $display("FAIL junk_pend pend=%b required 1", frame_pending);
    end
    check_drained("junk");
    do_swap();
  endtask

  task automatic test_timeout();
    logic [7:0] px [12];
    rand_pixels(px);
    expect_pixels(px, 1, 1'b0);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(px[i]);
    in_valid = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      @(negedge sys_clk);
      checks++;
      if (err_timeout !== (i == TO)) begin
        errors++;
        $display("FAIL timeout_pulse cycle %0d err=%b required %b", i, err_timeout, (i == TO));
      end
      if (i >= TO - 1) begin
        checks++;
        if (busy !== (i != TO)) begin
          errors++;
          $display("FAIL timeout_busy cycle %0d busy=%b required %b", i, busy, (i != TO));
        end
      end
    end
    checks++;
    if (frame_pending !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pend pend=%b required 0", frame_pending);
    end
    @(negedge sys_clk);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width err=%b required 0", err_timeout);
    end
    check_drained("timeout_part");
    rand_pixels(px);
    expect_pixels(px, NPX, 1'b1);
    send_frame(px, 3);
    in_valid = 1'b0;
    @(negedge sys_clk);
    check_drained("timeout_next");
    do_swap();
  endtask

  task automatic test_reset_mid();
    logic [7:0] px [12];
    rand_pixels(px);
    expect_pixels(px, 2, 1'b0);
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_byte(px[i]);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({fb_we, fb_waddr, fb_wdata, frame_pending, frame_done, err_timeout, busy} !== 39'd0) begin
      errors++;
      $display("FAIL rstmid_outs got we=%b addr=%0d data=%h pend=%b done=%b err=%b busy=%b required 0",
               fb_we, fb_waddr, fb_wdata, frame_pending, frame_done, err_timeout, busy);
    end
    rst = 1'b0;
    check_drained("rstmid_part");
    rand_pixels(px);
    expect_pixels(px, NPX, 1'b1);
    send_frame(px, 1);
    in_valid = 1'b0;
    @(negedge sys_clk);
    check_drained("rstmid_next");
    do_swap();
  endtask

  task automatic test_swap_collide();
    logic [7:0] px [12];
    do_swap();
    checks++;
    if (frame_pending !== 1'b0) begin
      errors++;
      $display("FAIL swap_idle pend=%b required 0", frame_pending);
    end
    rand_pixels(px);
    expect_pixels(px, NPX, 1'b1);
    send_frame(px, 0);
    in_valid = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL collide_done done=%b required 1", frame_done);
    end
    do_swap();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (frame_pending !== 1'b1) begin
        errors++;
        $display("FAIL collide_pend cycle %0d pend=%b required 1", i, frame_pending);
      end
      @(negedge sys_clk);
    end
    do_swap();
    checks++;
    if (frame_pending !== 1'b0) begin
      errors++;
      $display("FAIL collide_clear pend=%b required 0", frame_pending);
    end
    check_drained("collide");
  endtask

  task automatic test_random();
    logic [7:0] px [12];
    logic [7:0] junk;
    for (int f = 0; f < 6; f++) begin
      rand_pixels(px);
      expect_pixels(px, NPX, 1'b1);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk);
      end
      send_frame(px, TO - 2);
      in_valid = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (frame_pending !== 1'b1) begin
        errors++;
        $display("FAIL rand_pend frame %0d pend=%b required 1", f, frame_pending);
      end
      check_drained("rand");
      do_swap();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    @(negedge sys_clk);
    test_reset();
    test_back_to_back();
    test_pending_stall();
    test_junk();
    test_timeout();
    test_reset_mid();
    test_swap_collide();
    test_random();
    repeat (3) @(negedge sys_clk);
    check_drained("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
